// File: rtl/dec_pipe_stage.sv
// Decode stage: register file with write-back bypass, immediate generation, destination
// select, load-use interlock and a registered ID/EX bundle behind a valid/ready handshake.
module dec_pipe_stage #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int ADDR_W   = 32,
  parameter int LINK_REG = NREGS - 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       Instruction,
  input  logic [ADDR_W-1:0] InstrAddrIn,
  input  logic [1:0]        RegDst,
  input  logic [1:0]        ImmMode,
  input  logic              MemReadCtl,
  input  logic              RegWriteCtl,
  input  logic              UsesRt,
  input  logic              Flush,
  input  logic              WbEn,
  input  logic [AW-1:0]     WbAddr,
  input  logic [DATA_W-1:0] WbData,
  input  logic              OutReady,
  output logic              OutValid,
  output logic [ADDR_W-1:0] OutInstrAddr,
  output logic [DATA_W-1:0] OutRsData,
  output logic [DATA_W-1:0] OutRtData,
  output logic [DATA_W-1:0] OutImm,
  output logic [AW-1:0]     OutRsAddr,
  output logic [AW-1:0]     OutRtAddr,
  output logic [AW-1:0]     OutDstAddr,
  output logic              OutMemRead,
  output logic              OutRegWrite,
  output logic [15:0]       StallCount
);

  logic [DATA_W-1:0] rf_q [NREGS];

  logic              valid_q, valid_d, load_en;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
  logic [DATA_W-1:0] rs_data_d, rt_data_d, imm_d;
  logic [AW-1:0]     rs_addr_q, rt_addr_q, dst_q;
  logic [AW-1:0]     rs_idx, rt_idx, rd_idx, dst_d;
  logic              mem_read_q, reg_write_q;
  logic [15:0]       stall_q, stall_d;
  logic              hazard;

  assign rs_idx = Instruction[21 +: AW];
  assign rt_idx = Instruction[16 +: AW];
  assign rd_idx = Instruction[11 +: AW];

  function automatic logic [DATA_W-1:0] read_reg(input logic [AW-1:0] idx);
    if (idx == '0)                 return '0;
    else if (WbEn && WbAddr == idx) return WbData;
    else                            return rf_q[idx];
  endfunction

  // NOTE: the register file is cleared on reset, so it needs the reset loop and cannot map
  // onto a plain RAM macro.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (WbEn && WbAddr != '0) begin
      rf_q[WbAddr] <= WbData;
    end
  end

  assign hazard = valid_q && mem_read_q && dst_q != '0 &&
                  (dst_q == rs_idx || (UsesRt && dst_q == rt_idx));

  assign InReady = !Reset && !Flush && !hazard && (!valid_q || OutReady);

  // NOTE: every signal gets a default before the case/if tree so no latch can be inferred.
  always_comb begin
    rs_data_d = read_reg(rs_idx);
    rt_data_d = read_reg(rt_idx);
    imm_d     = '0;
    dst_d     = rt_idx;
    unique case (ImmMode)
      2'b00: imm_d = DATA_W'($signed(Instruction[15:0]));
      2'b01: imm_d = DATA_W'(Instruction[15:0]);
      2'b10: imm_d = DATA_W'($signed({Instruction[15:0], 16'h0000}));
      2'b11: imm_d = DATA_W'(Instruction[25:0]);
    endcase
    unique case (RegDst)
      2'b01:   dst_d = rd_idx;
      2'b10:   dst_d = AW'(LINK_REG);
      default: dst_d = rt_idx;
    endcase
  end

  always_comb begin
    load_en = 1'b0;
    valid_d = valid_q;
    stall_d = stall_q;
    if (Flush) begin
      valid_d = 1'b0;
    end else if (InValid && InReady) begin
      load_en = 1'b1;
      valid_d = 1'b1;
    end else if (OutReady) begin
      valid_d = 1'b0;
    end
    if (InValid && hazard && !Flush && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      valid_q     <= 1'b0;
      addr_q      <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      dst_q       <= '0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      valid_q <= valid_d;
      stall_q <= stall_d;
      if (load_en) begin
        addr_q      <= InstrAddrIn;
        rs_data_q   <= rs_data_d;
        rt_data_q   <= rt_data_d;
        imm_q       <= imm_d;
        rs_addr_q   <= rs_idx;
        rt_addr_q   <= rt_idx;
        dst_q       <= dst_d;
        mem_read_q  <= MemReadCtl;
        reg_write_q <= RegWriteCtl;
      end
    end
  end

  assign OutValid     = valid_q;
  assign OutInstrAddr = addr_q;
  assign OutRsData    = rs_data_q;
  assign OutRtData    = rt_data_q;
  assign OutImm       = imm_q;
  assign OutRsAddr    = rs_addr_q;
  assign OutRtAddr    = rt_addr_q;
  assign OutDstAddr   = dst_q;
  assign OutMemRead   = mem_read_q;
  assign OutRegWrite  = reg_write_q;
  assign StallCount   = stall_q;

endmodule

// File: tb/tb_dec_pipe_stage.sv
// Bench for dec_pipe_stage: directed scenarios plus randomized traffic, all compared
// against a transaction-level model of the decode stage kept here.
module tb_dec_pipe_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int XW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [31:0]   instr;
  logic [XW-1:0] instr_addr;
  logic [1:0]    reg_dst, imm_mode;
  logic          mem_read, reg_write, uses_rt, flush;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          out_ready, out_valid;
  logic [XW-1:0] out_addr;
  logic [DW-1:0] out_rs, out_rt, out_imm;
  logic [AW-1:0] out_rsa, out_rta, out_dst;
  logic          out_mr, out_rw;
  logic [15:0]   stall_cnt;

  dec_pipe_stage dut (
    .Clock(clk), .Reset(rst), .InValid(in_valid), .InReady(in_ready),
    .Instruction(instr), .InstrAddrIn(instr_addr), .RegDst(reg_dst), .ImmMode(imm_mode),
    .MemReadCtl(mem_read), .RegWriteCtl(reg_write), .UsesRt(uses_rt), .Flush(flush),
    .WbEn(wb_en), .WbAddr(wb_addr), .WbData(wb_data), .OutReady(out_ready),
    .OutValid(out_valid), .OutInstrAddr(out_addr), .OutRsData(out_rs), .OutRtData(out_rt),
    .OutImm(out_imm), .OutRsAddr(out_rsa), .OutRtAddr(out_rta), .OutDstAddr(out_dst),
    .OutMemRead(out_mr), .OutRegWrite(out_rw), .StallCount(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus the one bundle sitting in the stage.
  logic [31:0] m_regs [32];
  bit          m_valid, m_mr, m_rw;
  logic [31:0] m_addr, m_rs, m_rt, m_imm;
  int          m_rsa, m_rta, m_dst;
  int          m_stall;

  function automatic logic [31:0] m_read(input int idx);
    if (idx == 0) return 32'h0;
    if (wb_en && int'(wb_addr) == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] m_immgen(input logic [31:0] w, input logic [1:0] mode);
    int v;
    case (mode)
      2'd0: begin v = int'(w[15:0]); if (v >= 32768) v -= 65536; return 32'(v); end
      2'd1: return 32'(w[15:0]);
      2'd2: return w[15:0] * 32'd65536;
      default: return w % 32'd67108864;
    endcase
  endfunction

  function automatic bit m_hazard();
    int rs = int'(instr[25:21]);
    int rt = int'(instr[20:16]);
    return m_valid && m_mr && m_dst != 0 && (m_dst == rs || (uses_rt && m_dst == rt));
  endfunction

  function automatic bit m_ready();
    return !flush && !m_hazard() && (!m_valid || out_ready);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 0; m_mr = 0; m_rw = 0; m_addr = 0; m_rs = 0; m_rt = 0; m_imm = 0;
    m_rsa = 0; m_rta = 0; m_dst = 0; m_stall = 0;
  endtask

  task automatic m_edge();
    bit haz = m_hazard();
    bit rdy = m_ready();
    if (in_valid && haz && !flush && m_stall < 65535) m_stall++;
    if (flush) m_valid = 0;
    else if (in_valid && rdy) begin
      m_valid = 1;
      m_addr  = instr_addr;
      m_rsa   = int'(instr[25:21]);
      m_rta   = int'(instr[20:16]);
      m_rs    = m_read(m_rsa);
      m_rt    = m_read(m_rta);
      m_imm   = m_immgen(instr, imm_mode);
      m_dst   = (reg_dst == 2'b01) ? int'(instr[15:11]) : (reg_dst == 2'b10) ? 31 : m_rta;
      m_mr    = mem_read;
      m_rw    = reg_write;
    end else if (out_ready) m_valid = 0;
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    #1 check("in_ready", in_ready, m_ready());
    @(posedge clk);
    m_edge();
    #1;
    check("out_valid", out_valid, m_valid);
    check("stall_count", stall_cnt, m_stall);
    if (m_valid) begin
      check("out_addr", out_addr, m_addr);
      check("out_rs", out_rs, m_rs);
      check("out_rt", out_rt, m_rt);
      check("out_imm", out_imm, m_imm);
      check("out_rsa", out_rsa, m_rsa);
      check("out_rta", out_rta, m_rta);
      check("out_dst", out_dst, m_dst);
      check("out_mr", out_mr, m_mr);
      check("out_rw", out_rw, m_rw);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input int rs, input int rt, input logic [15:0] imm);
    return {6'h0, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic idle_inputs();
    in_valid = 0; instr = 0; instr_addr = 0; reg_dst = 0; imm_mode = 0;
    mem_read = 0; reg_write = 0; uses_rt = 0; flush = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
  endtask

  logic [31:0] held;

  initial begin
    rst = 1;
    idle_inputs();
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_stall", stall_cnt, 0);
    rst = 0;

    // Write reg 5, then read it through rs.
    wb_en = 1; wb_addr = 5; wb_data = 32'h1234_5678;
    tick();
    wb_en = 0; in_valid = 1; instr = mk(5, 0, 16'h0010); instr_addr = 32'h100;
    tick();
    check("wb5_rs", out_rs, 32'h1234_5678);

    // Same-cycle bypass, and write-back to r0 is ignored.
    wb_en = 1; wb_addr = 3; wb_data = 32'hDEAD_BEEF; instr = mk(3, 3, 16'h0); instr_addr = 32'h104;
    tick();
    check("byp_rs", out_rs, 32'hDEAD_BEEF);
    check("byp_rt", out_rt, 32'hDEAD_BEEF);
    wb_addr = 0; wb_data = 32'hFFFF_FFFF; instr = mk(0, 0, 16'h0); instr_addr = 32'h108;
    tick();
    check("r0_rs", out_rs, 0);
    check("r0_rt", out_rt, 0);

    // Load to r8 followed by a dependent instruction: one bubble.
    wb_en = 0; instr = mk(0, 8, 16'h0); mem_read = 1; reg_write = 1; instr_addr = 32'h10C;
    tick();
    instr = mk(8, 0, 16'h0); mem_read = 0; instr_addr = 32'h110;
    #1 check("lu_in_ready", in_ready, 0);
    tick();
    check("lu_bubble", out_valid, 0);
    check("lu_stall", stall_cnt, 1);
    tick();
    check("lu_accept", out_valid, 1);
    check("lu_rsa", out_rsa, 8);

    // Back-pressure: bundle holds while r8 is rewritten underneath it.
    held = out_rs;
    out_ready = 0; instr = mk(1, 2, 16'h0); instr_addr = 32'h114;
    wb_en = 1; wb_addr = 8; wb_data = 32'h0000_CAFE;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_rs_stable", out_rs, held);
      check("bp_addr_stable", out_addr, 32'h110);
    end
    wb_en = 0; flush = 1;
    tick();
    check("flush_valid", out_valid, 0);
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    check("flush_dropped", out_valid, 0);

    // Immediate modes on 16'h8000 and the link destination.
    in_valid = 1; instr = mk(0, 4, 16'h8000);
    imm_mode = 2'b00; tick(); check("imm_sext", out_imm, 32'hFFFF_8000);
    imm_mode = 2'b01; tick(); check("imm_zext", out_imm, 32'h0000_8000);
    imm_mode = 2'b10; tick(); check("imm_upper", out_imm, 32'h8000_0000);
    reg_dst = 2'b10; imm_mode = 2'b11; tick(); check("link_dst", out_dst, 31);

    // Reset while FULL: bundle gone immediately, registers cleared.
    out_ready = 0;
    rst = 1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 0);
    m_reset();
    @(negedge clk);
    rst = 0; out_ready = 1; reg_dst = 0; instr = mk(5, 3, 16'h0);
    tick();
    check("post_rst_r5", out_rs, 0);
    check("post_rst_r3", out_rt, 0);

    // Randomized traffic, biased towards load-use dependencies.
    for (int c = 0; c < 3000; c++) begin
      in_valid   = ($urandom_range(3) != 0);
      out_ready  = ($urandom_range(9) < 7);
      flush      = ($urandom_range(19) == 0);
      instr      = $urandom;
      if ($urandom_range(2) == 0) instr[25:21] = 5'(m_dst);
      if ($urandom_range(2) == 0) instr[20:16] = 5'(m_dst);
      instr_addr = $urandom;
      reg_dst    = 2'($urandom_range(3));
      imm_mode   = 2'($urandom_range(3));
      mem_read   = ($urandom_range(9) < 3);
      reg_write  = $urandom_range(1) == 1;
      uses_rt    = $urandom_range(1) == 1;
      wb_en      = $urandom_range(1) == 1;
      wb_addr    = 5'($urandom_range(31));
      wb_data    = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
